sync_control_multi: RTL and testbench

Step-synchronisation barrier for the diffusion datapath, generalising the two-engine step sync to `NUM_CH` engines. It tracks a per-channel arrival mask and advances a shared step counter `l_step` once every enabled channel has reported `finished` for the current step. It stops at a run-time or parameter step limit and flags protocol overruns. It sits between the PS control registers (`start`, mask, limit) and the diffusion engines (`finished`/`rdy`).

---
 rtl/sync_control_multi.sv | 82 ++++++++
 tb/tb_sync_control_multi.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sync_control_multi.sv
// sync_control_multi: step barrier across NUM_CH engines; advances l_step once every
// enabled channel has reported finished for the current step.
module sync_control_multi #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int MAX_STEPS  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [DATA_WIDTH-1:0] max_steps,
    input  logic [NUM_CH-1:0]     finished,
    output logic [NUM_CH-1:0]     rdy,
    output logic [DATA_WIDTH-1:0] l_step,
    output logic                  step_pulse,
    output logic                  finished_all,
    output logic                  busy,
    output logic                  err_overrun
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state;
    logic [NUM_CH-1:0]     mask, arrive, hit, seen;
    logic [DATA_WIDTH-1:0] limit, lim_sel;
    assign hit     = finished & mask;
    assign seen    = arrive | hit;
    assign lim_sel = (max_steps == '0) ? DATA_WIDTH'(MAX_STEPS) : max_steps;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mask         <= '0;
            limit        <= '0;
            arrive       <= '0;
            rdy          <= '0;
            l_step       <= '0;
            step_pulse   <= 1'b0;
            finished_all <= 1'b0;
            busy         <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                arrive       <= '0;
                rdy          <= '0;
                finished_all <= 1'b0;
                busy         <= 1'b0;
            end else if (start && state != RUN) begin
                mask         <= ch_enable;
                limit        <= lim_sel;
                l_step       <= '0;
                arrive       <= '0;
                err_overrun  <= 1'b0;
                state        <= (ch_enable == '0) ? DONE : RUN;
                finished_all <= (ch_enable == '0);
                busy         <= (ch_enable != '0);
                rdy          <= ch_enable;
            end else if (state == RUN) begin
                if ((hit & arrive) != '0)
                    err_overrun <= 1'b1;
                // Arrivals in the completing cycle count toward the current step.
                if (seen == mask) begin
                    l_step     <= l_step + 1'b1;
                    step_pulse <= 1'b1;
                    arrive     <= '0;
                    if (l_step + 1'b1 == limit) begin
                        state        <= DONE;
                        rdy          <= '0;
                        finished_all <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        rdy <= mask;
                    end
                end else begin
                    arrive <= seen;
                    rdy    <= mask & ~seen;
                end
            end
        end
    end
endmodule

// File: tb/tb_sync_control_multi.sv
// tb_sync_control_multi: vector table driven through an expected-value queue, plus
// hand-written async-reset sequences.
module tb_sync_control_multi;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [3:0]  ch_enable = '0, finished = '0;
    logic [31:0] max_steps = '0;
    logic [3:0]  rdy;
    logic [31:0] l_step;
    logic        step_pulse, finished_all, busy, err_overrun;
    int          total = 0, bad = 0;

    localparam logic [3:0] F = 4'hF;

    typedef struct {
        logic        st, ab;
        logic [3:0]  en;
        logic [31:0] ms;
        logic [3:0]  fin;
        logic [39:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [39:0] exp_q[$];

    sync_control_multi dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_enable(ch_enable),
        .max_steps(max_steps), .finished(finished), .rdy(rdy), .l_step(l_step),
        .step_pulse(step_pulse), .finished_all(finished_all), .busy(busy),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic ab, input logic [3:0] en,
                                input logic [31:0] ms, input logic [3:0] fin,
                                input logic [3:0] r, input logic [31:0] ls, input logic sp,
                                input logic fa, input logic bz, input logic er);
        vec_t v;
        v.st = st; v.ab = ab; v.en = en; v.ms = ms; v.fin = fin;
        v.exp = {r, ls, sp, fa, bz, er};
        return v;
    endfunction

    function automatic logic [39:0] outs();
        return {rdy, l_step, step_pulse, finished_all, busy, err_overrun};
    endfunction

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got rdy=%h l_step=%0d sp=%b fa=%b busy=%b err=%b, want rdy=%h l_step=%0d sp=%b fa=%b busy=%b err=%b",
                     name, got[39:36], got[35:4], got[3], got[2], got[1], got[0],
                     want[39:36], want[35:4], want[3], want[2], want[1], want[0]);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        start = v.st; abort = v.ab; ch_enable = v.en; max_steps = v.ms; finished = v.fin;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        check(name, outs(), exp_q.pop_front());
    endtask

    initial begin
        // basic run: all four channels together, default limit of 7
        vecs.push_back(mk(1,0,F,0,0, F,0,0,0,1,0));
        for (int k = 1; k <= 7; k++)
            vecs.push_back(mk(0,0,0,0,F, (k < 7) ? F : 4'h0, k, 1, k == 7, k < 7, 0));
        vecs.push_back(mk(0,0,0,0,0, 0,7,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,F, 0,7,0,1,0,0));
        // staggered arrivals, ch1 disabled
        vecs.push_back(mk(1,0,5,3,0, 5,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 5,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1, 4,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,2, 4,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 4,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,4, 5,1,1,0,1,0));
        // overrun on ch0, step still advances once
        vecs.push_back(mk(0,0,0,0,1, 4,1,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1, 4,1,0,0,1,1));
        vecs.push_back(mk(0,0,0,0,4, 5,2,1,0,1,1));
        vecs.push_back(mk(0,0,0,0,5, 0,3,1,1,0,1));
        vecs.push_back(mk(0,0,0,0,0, 0,3,0,1,0,1));
        // empty mask
        vecs.push_back(mk(1,0,0,5,0, 0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,F, 0,0,0,1,0,0));
        // abort against final arrivals at l_step=2
        vecs.push_back(mk(1,0,3,0,0, 3,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,3, 3,1,1,0,1,0));
        vecs.push_back(mk(0,0,0,0,3, 3,2,1,0,1,0));
        vecs.push_back(mk(0,0,0,0,1, 2,2,0,0,1,0));
        vecs.push_back(mk(0,1,0,0,2, 0,2,0,0,0,0));
        vecs.push_back(mk(1,1,F,0,0, 0,2,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,F, 0,2,0,0,0,0));
        // start during RUN is ignored
        vecs.push_back(mk(1,0,F,2,0, F,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1, 4'hE,0,0,0,1,0));
        vecs.push_back(mk(1,0,1,9,0, 4'hE,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,4'hE, F,1,1,0,1,0));
        vecs.push_back(mk(0,0,0,0,F, 0,2,1,1,0,0));
        // restart from DONE with limit 2, then abort in DONE
        vecs.push_back(mk(1,0,F,2,0, F,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,F, F,1,1,0,1,0));
        vecs.push_back(mk(0,0,0,0,F, 0,2,1,1,0,0));
        vecs.push_back(mk(0,1,0,0,0, 0,2,0,0,0,0));

        #12;
        check("reset_state", outs(), 40'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset between edges mid-step
        apply(mk(1,0,F,0,0, F,0,0,0,1,0), "rst_run_start");
        apply(mk(0,0,0,0,F, F,1,1,0,1,0), "rst_run_step");
        apply(mk(0,0,0,0,1, 4'hE,1,0,0,1,0), "rst_run_partial");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_reset", outs(), 40'h0);
        #2;
        rst = 1'b1;
        apply(mk(1,0,3,1,0, 3,0,0,0,1,0), "post_reset_start");
        apply(mk(0,0,0,0,3, 0,1,1,1,0,0), "post_reset_done");
        apply(mk(0,0,0,0,0, 0,1,0,1,0,0), "post_reset_pulse_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
